// File: rtl/user_clock_pkg.sv
// user_clock_pkg: shared types and default constants for the user clock generator.
//   mode_t  - encoding of the mode switches (00 slow, 01 single-step, 10 fast, 11 fastest)
//   state_t - generator FSM states
//   DEF_*   - board-rate defaults for divider and debounce parameters
package user_clock_pkg;

    typedef enum logic [1:0] {
        MODE_SLOW       = 2'b00,
        MODE_SINGLESTEP = 2'b01,
        MODE_FAST       = 2'b10,
        MODE_FASTEST    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BURST_HI,
        ST_BURST_LO
    } state_t;

    localparam int unsigned DEF_DIV_W           = 32;
    localparam int unsigned DEF_DIV_SLOW        = 25000000;
    localparam int unsigned DEF_DIV_FAST        = 2000000;
    localparam int unsigned DEF_DIV_FASTEST     = 100000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_BURST_W         = 8;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronise a raw button, debounce it and emit a one-cycle press pulse.
//   clk_i   - sampling clock
//   rst_ni  - asynchronous active-low reset
//   btn_i   - raw asynchronous button level, active-high
//   press_o - one-cycle pulse on the debounced 0->1 edge
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES == 0) begin : g_deb_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic          s1_q, s2_q, db_q, db_d, press_q, press_d, diff, done;
    logic [CW-1:0] cnt_q, cnt_d;

    // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        diff    = s2_q != db_q;
        done    = diff && (cnt_q == LAST);
        cnt_d   = (diff && !done) ? cnt_q + 1'b1 : '0;
        db_d    = done ? s2_q : db_q;
        press_d = done && s2_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/user_clock_gen.sv
// user_clock_gen: user-controlled CPU clock with speed presets and a debounced step burst.
//   source_clock - system clock
//   reset_n      - asynchronous active-low reset
//   step         - raw step push-button, active-high
//   mode         - 00 slow, 10 fast, 11 fastest, 01 single-step
//   burst_len    - periods emitted per step press (0 behaves as 1)
//   out_clock    - generated CPU clock
//   tick         - one-cycle strobe in the cycle out_clock rises
//   busy         - high while a step burst is in progress
module user_clock_gen
    import user_clock_pkg::*;
#(
    parameter int unsigned DIV_W           = DEF_DIV_W,
    parameter int unsigned DIV_SLOW        = DEF_DIV_SLOW,
    parameter int unsigned DIV_FAST        = DEF_DIV_FAST,
    parameter int unsigned DIV_FASTEST     = DEF_DIV_FASTEST,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BURST_W         = DEF_BURST_W
) (
    input  logic               source_clock,
    input  logic               reset_n,
    input  logic               step,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
    output logic               out_clock,
    output logic               tick,
    output logic               busy
);

    if (DIV_SLOW == 0 || DIV_FAST == 0 || DIV_FASTEST == 0) begin : g_div_check
        $error("every DIV_* parameter must be at least 1");
    end

    localparam logic [DIV_W-1:0] LAST_SLOW    = DIV_W'(DIV_SLOW - 1);
    localparam logic [DIV_W-1:0] LAST_FAST    = DIV_W'(DIV_FAST - 1);
    localparam logic [DIV_W-1:0] LAST_FASTEST = DIV_W'(DIV_FASTEST - 1);

    state_t             state_q, state_d;
    mode_t              run_q, run_d, mode_in;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               out_q, out_d, tick_q, tick_d, busy_q, busy_d, press;

    function automatic logic [DIV_W-1:0] last_of(input mode_t m);
        return (m == MODE_FASTEST) ? LAST_FASTEST : (m == MODE_FAST) ? LAST_FAST : LAST_SLOW;
    endfunction

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .clk_i  (source_clock),
        .rst_ni (reset_n),
        .btn_i  (step),
        .press_o(press)
    );

    assign mode_in = mode_t'(mode);

    // run_q holds the preset the divider is counting at, so a switch to
    // single-step can still finish the current high phase at the old rate.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        out_d   = out_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                out_d = 1'b0;
                cnt_d = '0;
                if (mode_in != MODE_SINGLESTEP) begin
                    state_d = ST_RUN;
                    run_d   = mode_in;
                end else if (press) begin
                    state_d = ST_BURST_HI;
                    burst_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
                    out_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (mode_in != MODE_SINGLESTEP && mode_in != run_q) begin
                    cnt_d = '0;
                    run_d = mode_in;
                end else if (mode_in == MODE_SINGLESTEP && !out_q) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == last_of(run_q)) begin
                    cnt_d   = '0;
                    out_d   = !out_q;
                    state_d = (mode_in == MODE_SINGLESTEP) ? ST_IDLE : ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BURST_HI: begin
                if (cnt_q == LAST_FASTEST) begin
                    cnt_d   = '0;
                    out_d   = 1'b0;
                    burst_d = burst_q - 1'b1;
                    state_d = ST_BURST_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BURST_LO: begin
                if (cnt_q == LAST_FASTEST) begin
                    cnt_d   = '0;
                    out_d   = burst_q != '0;
                    busy_d  = burst_q != '0;
                    state_d = (burst_q == '0) ? ST_IDLE : ST_BURST_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tick_d = out_d && !out_q;
    end

    always_ff @(posedge source_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            run_q   <= MODE_SLOW;
            cnt_q   <= '0;
            burst_q <= '0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign out_clock = out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_user_clock_gen.sv
// tb_user_clock_gen: directed, table-driven bench for user_clock_gen with small dividers.
module tb_user_clock_gen;
    import user_clock_pkg::*;

    logic       source_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       step = 1'b0;
    logic [1:0] mode = MODE_SLOW;
    logic [7:0] burst_len = 8'd0;
    logic       out_clock, tick, busy;
    int         n_checks = 0;
    int         n_fail = 0;

    user_clock_gen #(
        .DIV_W(32), .DIV_SLOW(8), .DIV_FAST(4), .DIV_FASTEST(2),
        .DEBOUNCE_CYCLES(4), .BURST_W(8)
    ) dut (
        .source_clock(source_clock),
        .reset_n     (reset_n),
        .step        (step),
        .mode        (mode),
        .burst_len   (burst_len),
        .out_clock   (out_clock),
        .tick        (tick),
        .busy        (busy)
    );

    always #5 source_clock = ~source_clock;

    typedef struct {
        int         grp;
        logic       stp;
        logic [1:0] md;
        logic [7:0] bl;
        int         n;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out/tick/busy=%b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge source_clock);
        #1;
    endtask

    function automatic logic [2:0] obs();
        return {out_clock, tick, busy};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fast_exp [7];
        fast_exp = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11};

        // group 1: clean press, burst_len 3 -> three 2-high/2-low periods, busy for 12 cycles
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 6, 3'b000});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 1, 3'b111});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 1, 3'b101});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 2, 3'b001});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 1, 3'b111});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 1, 3'b101});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 2, 3'b001});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 1, 3'b111});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 1, 3'b101});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 2, 3'b001});
        tbl.push_back('{1, 1'b1, MODE_SINGLESTEP, 8'd3, 2, 3'b000});
        tbl.push_back('{1, 1'b0, MODE_SINGLESTEP, 8'd3, 10, 3'b000});
        // group 2: bouncing step then held, burst_len 0 -> exactly one period
        tbl.push_back('{2, 1'b1, MODE_SINGLESTEP, 8'd0, 1, 3'b000});
        tbl.push_back('{2, 1'b0, MODE_SINGLESTEP, 8'd0, 1, 3'b000});
        tbl.push_back('{2, 1'b1, MODE_SINGLESTEP, 8'd0, 1, 3'b000});
        tbl.push_back('{2, 1'b0, MODE_SINGLESTEP, 8'd0, 1, 3'b000});
        tbl.push_back('{2, 1'b1, MODE_SINGLESTEP, 8'd0, 6, 3'b000});
        tbl.push_back('{2, 1'b1, MODE_SINGLESTEP, 8'd0, 1, 3'b111});
        tbl.push_back('{2, 1'b1, MODE_SINGLESTEP, 8'd0, 1, 3'b101});
        tbl.push_back('{2, 1'b1, MODE_SINGLESTEP, 8'd0, 2, 3'b001});
        tbl.push_back('{2, 1'b0, MODE_SINGLESTEP, 8'd0, 10, 3'b000});
        // group 3: burst of 4, second press and mode->fast mid-burst, then RUN at H=4
        tbl.push_back('{3, 1'b1, MODE_SINGLESTEP, 8'd4, 6, 3'b000});
        tbl.push_back('{3, 1'b1, MODE_SINGLESTEP, 8'd4, 1, 3'b111});
        tbl.push_back('{3, 1'b0, MODE_SINGLESTEP, 8'd4, 1, 3'b101});
        tbl.push_back('{3, 1'b0, MODE_SINGLESTEP, 8'd4, 2, 3'b001});
        tbl.push_back('{3, 1'b0, MODE_SINGLESTEP, 8'd4, 1, 3'b111});
        tbl.push_back('{3, 1'b0, MODE_SINGLESTEP, 8'd4, 1, 3'b101});
        tbl.push_back('{3, 1'b0, MODE_SINGLESTEP, 8'd4, 1, 3'b001});
        tbl.push_back('{3, 1'b1, MODE_SINGLESTEP, 8'd4, 1, 3'b001});
        tbl.push_back('{3, 1'b1, MODE_SINGLESTEP, 8'd4, 1, 3'b111});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 1, 3'b101});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 2, 3'b001});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 1, 3'b111});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 1, 3'b101});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 2, 3'b001});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 5, 3'b000});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 1, 3'b110});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 3, 3'b100});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 4, 3'b000});
        tbl.push_back('{3, 1'b1, MODE_FAST,       8'd4, 1, 3'b110});

        // reset values
        cyc();
        cyc();
        check("reset", obs(), 3'b000);
        reset_n = 1'b1;

        // slow preset: period 16, first rise 8 cycles after RUN entry
        for (int k = 1; k <= 64; k++) begin
            cyc();
            check($sformatf("slow k=%0d", k), obs(),
                  {k >= 9 && ((k - 9) / 8) % 2 == 0, k >= 9 && (k - 9) % 16 == 0, 1'b0});
        end
        reset_n = 1'b0;
        #1;
        check("reset mid-high", obs(), 3'b000);
        cyc();
        reset_n = 1'b1;

        // slow -> fastest while low at counter 5
        for (int k = 1; k <= 54; k++) begin
            cyc();
            check($sformatf("slow2 k=%0d", k), obs(),
                  {k >= 9 && ((k - 9) / 8) % 2 == 0, k >= 9 && (k - 9) % 16 == 0, 1'b0});
        end
        mode = MODE_FASTEST;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check($sformatf("fastest k=%0d", 55 + i), obs(), {fast_exp[i], 1'b0});
        end

        // single-step while high: high phase finishes, then IDLE
        mode = MODE_SINGLESTEP;
        cyc();
        check("to_step hold", obs(), 3'b100);
        cyc();
        check("to_step fall", obs(), 3'b000);
        cyc();
        check("idle", obs(), 3'b000);

        for (int r = 0; r < tbl.size(); r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                step      = tbl[r].stp;
                mode      = tbl[r].md;
                burst_len = tbl[r].bl;
                cyc();
                check($sformatf("grp%0d row%0d cyc%0d", tbl[r].grp, r, c), obs(), tbl[r].exp);
            end
        end

        // fast RUN, switch to single-step just after a rise: full 4-cycle high phase
        mode = MODE_SINGLESTEP;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("fast finish %0d", i), obs(), 3'b100);
        end
        cyc();
        check("fast finish low", obs(), 3'b000);

        // reset during BURST_HI
        reset_n = 1'b0;
        step = 1'b0;
        cyc();
        check("reset2", obs(), 3'b000);
        burst_len = 8'd3;
        step = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("pre-burst %0d", i), obs(), 3'b000);
        end
        cyc();
        check("burst start", obs(), 3'b111);
        #3;
        reset_n = 1'b0;
        #1;
        check("reset in BURST_HI", obs(), 3'b000);
        @(posedge source_clock);
        #1;
        step = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("post-reset idle %0d", i), obs(), 3'b000);
        end
        mode = MODE_SLOW;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check($sformatf("idle->run %0d", i), obs(), 3'b000);
        end
        cyc();
        check("idle->run rise", obs(), 3'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/user_clock_gen.md
Name: user_clock_gen

Overview:
- Next-generation user-controlled CPU clock source: parametrised speed presets, a debounced single-step button and a multi-period step burst.
- Produces a divided `out_clock` plus a one-cycle `tick` strobe marking each `out_clock` rising edge.
- Sits between board buttons/switches and the CPU clock input.
- Fully synchronous to `source_clock`, sampled on posedge.

Parameters:
- `DIV_W`, 32, width of divider constants and the half-period counter.
- `DIV_SLOW`, 25000000, half-period in `source_clock` cycles for the slow preset.
- `DIV_FAST`, 2000000, half-period for the fast preset.
- `DIV_FASTEST`, 100000, half-period for the fastest preset; also used for burst periods.
- `DEBOUNCE_CYCLES`, 250000, number of cycles a synchronised step level must be stable before it is accepted.
- `BURST_W`, 8, width of `burst_len`.

Ports:
- `source_clock`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `step`  in  1  raw push-button, asynchronous, active-high
- `mode`  in  2  00 slow, 10 fast, 11 fastest, 01 single-step
- `burst_len`  in  `BURST_W`  periods emitted per step press; 0 is treated as 1
- `out_clock`  out  1  generated CPU clock
- `tick`  out  1  one-cycle pulse in the cycle `out_clock` goes 0->1
- `busy`  out  1  high while a step burst is in progress

Behaviour:
- Reset is asynchronous, active-low; release is synchronous.
- Reset values: `out_clock`=0, `tick`=0, `busy`=0, half-period counter=0, burst counter=0, debounced step=0, FSM=IDLE, both synchroniser flops=0.
- Step input path:
  - 2-FF synchroniser on `step`.
  - Debouncer: counter restarts whenever the synchronised level differs from the debounced level.
  - The debounced level updates after `DEBOUNCE_CYCLES` consecutive differing samples.
  - `press` = one-cycle pulse on the debounced 0->1 edge. Press latency is 2 + `DEBOUNCE_CYCLES` cycles from a clean edge.
- Divider selection is combinational from `mode`. Half-period `H` = `DIV_*`; each `out_clock` level lasts exactly `H` cycles. The counter runs 0..H-1 and toggles `out_clock` on reaching H-1, then wraps to 0.
- FSM states: IDLE, RUN, BURST_HI, BURST_LO.
- IDLE:
  - `out_clock` held at 0.
  - `mode`!=01 -> RUN with counter cleared.
  - `mode`==01 and `press` -> BURST_HI. Load the burst counter with `burst_len` (0 loads 1), set `out_clock`=1, pulse `tick`, set `busy`=1.
- RUN:
  - Free-running divider at the selected `H`.
  - `mode` changing between run presets: clear the counter and keep the `out_clock` level; the next toggle occurs after the new `H` cycles.
  - `mode`->01: if `out_clock`=1, finish the current high phase at the old `H`, then go low and enter IDLE. If 0, enter IDLE immediately with the counter cleared. Never truncate a high phase.
  - `press` is ignored in RUN.
- BURST_HI: after `DIV_FASTEST` cycles, `out_clock`<=0, decrement the burst counter, go to BURST_LO.
- BURST_LO: after `DIV_FASTEST` cycles:
  - If the burst counter is 0: `busy`<=0, -> IDLE.
  - Otherwise: `out_clock`<=1, pulse `tick`, -> BURST_HI.
- Burst rules:
  - A burst always completes, even if `mode` changes mid-burst; a new mode is acted on from IDLE.
  - Presses during a burst are dropped, not queued.
- `tick` is asserted in the same cycle `out_clock` is registered 1 after being 0 (registered alongside it), in every state.
- Reset mid-burst or mid-phase: immediate return to reset values.
- Counter width: all compares are done at `DIV_W` width. A `DIV_*` value of 0 is illegal; an elaboration-time assertion requires every `DIV_*` to be at least 1.

Decomposition:
- Package `user_clock_pkg`: `mode_t` enum (`MODE_SLOW`, `MODE_SINGLESTEP`, `MODE_FAST`, `MODE_FASTEST`), FSM state enum, default divider constants.
- Sub-module `button_debounce`: synchroniser, debounce counter and rising-edge `press` output, parametrised by `DEBOUNCE_CYCLES`. It is reusable for other panel buttons.

Test Plan (DIV_SLOW=8, DIV_FAST=4, DIV_FASTEST=2, DEBOUNCE_CYCLES=4):
- Reset, then `mode`=00 for 64 cycles -> `out_clock` period 16 cycles with 8 high; one `tick` per period; first rise 8 cycles after RUN entry.
- `mode` 00->11 while `out_clock`=0 at counter 5 -> next rise exactly 2 cycles later; period 4 thereafter.
- `mode`=01, `burst_len`=3, clean press -> `press` 6 cycles later; exactly 3 `out_clock` pulses of 2 high/2 low; `busy` high 12 cycles; 3 `tick`s.
- `step` bouncing 1,0,1,0 at 1-cycle intervals then held high 10 cycles, `burst_len`=0 -> exactly one period emitted.
- Second press during a burst, plus `mode`->10 mid-burst -> burst count unchanged, then RUN at H=4 after `busy` falls.
- `reset_n` low during BURST_HI -> `out_clock`, `busy`, `tick` all 0 within the same cycle; FSM in IDLE after release.
